// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - shared types and constants for the key event decoder
package key_event_pkg;

    // Width of the debounce counter, event timer and repeat counter.
    localparam int TMR_W = 26;

    // Default timing for a 50 MHz sys_clk (all values are cycles minus 1).
    localparam int DEF_CNT_DEB    = 999_999;     // 20 ms
    localparam int DEF_LONG_MAX   = 49_999_999;  // 1 s
    localparam int DEF_DBL_GAP    = 14_999_999;  // 300 ms
    localparam int DEF_REPEAT_MAX = 9_999_999;   // 200 ms

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HELD1     = 3'd1,
        LONG_HELD = 3'd2,
        GAP       = 3'd3,
        HELD2     = 3'd4
    } state_t;

endpackage

// File: rtl/key_level_deb.sv
// rtl/key_level_deb.sv - key synchroniser and two-edge debouncer
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   key_in   in   raw key, 0 = pressed, asynchronous to clk
//   key_down out  debounced level, 1 = pressed
//   press_p  out  high in the cycle before key_down rises
//   rel_p    out  high in the cycle before key_down falls
module key_level_deb
    import key_event_pkg::*;
#(
    parameter int CNT_DEB = DEF_CNT_DEB
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_down,
    output logic press_p,
    output logic rel_p
);

    localparam logic [TMR_W-1:0] DEB_END = TMR_W'(CNT_DEB);

    logic             sync1;
    logic             sync2;
    logic [TMR_W-1:0] cnt;
    logic             pressed;
    logic             hit;

    assign pressed = ~sync2;
    // Input has disagreed with key_down for CNT_DEB+1 cycles: accept it.
    assign hit     = (pressed != key_down) && (cnt == DEB_END);
    // Edge pulses coincide with the accepting cycle so the FSM moves on the
    // same clock edge that updates key_down.
    assign press_p = hit & pressed;
    assign rel_p   = hit & ~pressed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            cnt      <= '0;
            key_down <= 1'b0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
            if (pressed == key_down) begin
                cnt <= '0;
            end else if (hit) begin
                cnt      <= '0;
                key_down <= ~key_down;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - classifies key gestures into short/long/double pulses
//
// Ports:
//   sys_clk      in   system clock, 50 MHz
//   sys_rst      in   asynchronous active-high reset
//   key_in       in   raw key, 0 = pressed, asynchronous to sys_clk
//   key_down     out  debounced level, 1 = pressed
//   short_press  out  one-cycle pulse
//   long_press   out  one-cycle pulse
//   double_click out  one-cycle pulse
//
// Optional feature macro KEY_REPEAT_EN: while a long press is held,
// long_press repeats every REPEAT_MAX+1 cycles (REPEAT_MAX exists only then).
module key_event_decoder
    import key_event_pkg::*;
#(
    parameter int CNT_DEB    = DEF_CNT_DEB,
    parameter int LONG_MAX   = DEF_LONG_MAX,
    parameter int DBL_GAP    = DEF_DBL_GAP
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_MAX = DEF_REPEAT_MAX
`endif
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_down,
    output logic short_press,
    output logic long_press,
    output logic double_click
);

    localparam logic [TMR_W-1:0] LONG_END = TMR_W'(LONG_MAX);
    localparam logic [TMR_W-1:0] GAP_END  = TMR_W'(DBL_GAP);
    localparam logic [TMR_W-1:0] TMR_SAT  = '1;

    logic             press_p;
    logic             rel_p;
    state_t           state;
    state_t           state_nx;
    logic [TMR_W-1:0] timer;
    logic             short_nx;
    logic             long_nx;
    logic             dbl_nx;

    key_level_deb #(
        .CNT_DEB (CNT_DEB)
    ) u_deb (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .key_in   (key_in),
        .key_down (key_down),
        .press_p  (press_p),
        .rel_p    (rel_p)
    );

`ifdef KEY_REPEAT_EN
    localparam logic [TMR_W-1:0] RPT_END = TMR_W'(REPEAT_MAX);
    logic [TMR_W-1:0] rpt;

    // Zero on entry to LONG_HELD because it is held clear in every other state.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rpt <= '0;
        end else if (state != LONG_HELD || rpt == RPT_END) begin
            rpt <= '0;
        end else begin
            rpt <= rpt + 1'b1;
        end
    end
`endif

    // Release/press checks come first so they win over a coincident timeout.
    always_comb begin
        state_nx = state;
        short_nx = 1'b0;
        long_nx  = 1'b0;
        dbl_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (press_p) state_nx = HELD1;
            end
            HELD1: begin
                if (rel_p) begin
                    state_nx = GAP;
                end else if (timer == LONG_END) begin
                    long_nx  = 1'b1;
                    state_nx = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (rel_p) begin
                    state_nx = IDLE;
                end
`ifdef KEY_REPEAT_EN
                else if (rpt == RPT_END) begin
                    long_nx = 1'b1;
                end
`endif
            end
            GAP: begin
                if (press_p) begin
                    state_nx = HELD2;
                end else if (timer == GAP_END) begin
                    short_nx = 1'b1;
                    state_nx = IDLE;
                end
            end
            HELD2: begin
                if (rel_p) begin
                    dbl_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= IDLE;
            timer        <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
        end else begin
            state        <= state_nx;
            short_press  <= short_nx;
            long_press   <= long_nx;
            double_click <= dbl_nx;
            if (state_nx != state) begin
                timer <= '0;
            end else if (timer != TMR_SAT) begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - scoreboard testbench for key_event_decoder
module tb_key_event_decoder;

    localparam int K_SHORT = 1;
    localparam int K_LONG  = 2;
    localparam int K_DBL   = 3;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic key_in  = 1'b1;
    logic key_down;
    logic short_press;
    logic long_press;
    logic double_click;

    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;
    ev_t sb[$];

    key_event_decoder #(
        .CNT_DEB    (3),
        .LONG_MAX   (20),
        .DBL_GAP    (10)
`ifdef KEY_REPEAT_EN
        ,
        .REPEAT_MAX (8)
`endif
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .key_in       (key_in),
        .key_down     (key_down),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b at cyc %0d", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic sb_empty(input string name);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d expected events never seen, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Drive a level for n cycles (called at a negedge). key_down must
    // follow CNT_DEB+3 = 6 sample cycles after the change.
    task automatic hold(input logic lvl, input int n, input string tag);
        int   n0;
        logic prev;
        prev   = (key_in == 1'b0);
        key_in = lvl;
        n0     = cyc;
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            if (cyc == n0 + 5) check({tag, "_kd_before"}, key_down, prev);
            if (cyc == n0 + 6) check({tag, "_kd_after"}, key_down, (lvl == 1'b0));
        end
    endtask

    // Monitor: every event pulse must match the head of the scoreboard.
    always @(negedge sys_clk) begin
        int  kind;
        ev_t e;
        if (!sys_rst && (short_press || long_press || double_click)) begin
            kind = short_press ? K_SHORT : (long_press ? K_LONG : K_DBL);
            total++;
            if (32'(short_press) + 32'(long_press) + 32'(double_click) > 1) begin
                bad++;
                $display("FAIL onehot: pulses s=%0b l=%0b d=%0b, want one at cyc %0d",
                         short_press, long_press, double_click, cyc);
            end else if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected: kind %0d at cyc %0d, want none", kind, cyc);
            end else begin
                e = sb.pop_front();
                if (e.kind != kind || e.cyc != cyc) begin
                    bad++;
                    $display("FAIL event: kind %0d cyc %0d, want kind %0d cyc %0d",
                             kind, cyc, e.kind, e.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(negedge sys_clk);
        check("rst_key_down", key_down, 1'b0);
        check("rst_short", short_press, 1'b0);
        check("rst_long", long_press, 1'b0);
        check("rst_double", double_click, 1'b0);
        sys_rst = 1'b0;
        hold(1'b1, 5, "idle");

        // 1: short press
        hold(1'b0, 10, "t1p");
        expect_ev(K_SHORT, cyc + 17);
        hold(1'b1, 30, "t1r");
        sb_empty("t1_short");

        // 2: long press, held 40
        t = cyc;
        expect_ev(K_LONG, t + 27);
`ifdef KEY_REPEAT_EN
        expect_ev(K_LONG, t + 36);
        expect_ev(K_LONG, t + 45);
`endif
        hold(1'b0, 40, "t2p");
        hold(1'b1, 30, "t2r");
        sb_empty("t2_long");

        // 3: double click
        hold(1'b0, 8, "t3p1");
        hold(1'b1, 5, "t3r1");
        hold(1'b0, 8, "t3p2");
        expect_ev(K_DBL, cyc + 6);
        hold(1'b1, 30, "t3r2");
        sb_empty("t3_double");

        // 4: 2-cycle glitches never reach key_down
        for (int r = 0; r < 10; r++) begin
            key_in = 1'b0;
            repeat (2) begin
                @(negedge sys_clk);
                check("t4_glitch_kd", key_down, 1'b0);
            end
            key_in = 1'b1;
            repeat (3) begin
                @(negedge sys_clk);
                check("t4_glitch_kd", key_down, 1'b0);
            end
        end
        hold(1'b1, 10, "t4idle");
        sb_empty("t4_glitch");

        // 5: reset while in GAP drops the pending short press
        hold(1'b0, 8, "t5p");
        hold(1'b1, 10, "t5r");
        sys_rst = 1'b1;
        #1;
        check("t5_rst_key_down", key_down, 1'b0);
        check("t5_rst_short", short_press, 1'b0);
        check("t5_rst_long", long_press, 1'b0);
        check("t5_rst_double", double_click, 1'b0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        hold(1'b1, 30, "t5idle");
        check("t5_post_key_down", key_down, 1'b0);
        sb_empty("t5_reset");

        // 6: hold 50 cycles (repeat behaviour depends on the macro)
        t = cyc;
        expect_ev(K_LONG, t + 27);
`ifdef KEY_REPEAT_EN
        expect_ev(K_LONG, t + 36);
        expect_ev(K_LONG, t + 45);
        expect_ev(K_LONG, t + 54);
`endif
        hold(1'b0, 50, "t6p");
        hold(1'b1, 30, "t6r");
        sb_empty("t6_repeat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
